// File: rtl/a2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : a2_pkg
// Purpose  : Shared widths and types for the 8-bit pipelined datapath.
//            DATA_W   - datapath / register width
//            ADDR_W   - register address width
//            NUM_REGS - number of architectural registers
//            ex_wb_t  - EX/WB pipeline register bundle {write_reg, rd, data}
// Revision : 1.0 - initial release
// ============================================================================
package a2_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef struct packed {
        logic              write_reg;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } ex_wb_t;

endpackage : a2_pkg
`default_nettype wire

// File: rtl/a2_register_file.sv
`default_nettype none
// ============================================================================
// Module   : a2_register_file
// Purpose  : 2^ADDR_W x DATA_W register array. One synchronous write port,
//            two asynchronous read ports, synchronous active-high reset that
//            clears every entry. No hardwired zero register.
// Ports    : clk, rst                      - clock / synchronous reset
//            i_we, i_waddr, i_wdata        - write port
//            i_raddr1/2 -> o_rdata1/2      - combinational read ports
// Revision : 1.0 - initial release
// ============================================================================
module a2_register_file #(
    parameter int DATA_W = a2_pkg::DATA_W,
    parameter int ADDR_W = a2_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);

    localparam int C_NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [C_NUM_REGS];

    // Reset has priority, so a write pending at the reset edge is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule : a2_register_file
`default_nettype wire

// File: rtl/a2_writeback.sv
`default_nettype none
// ============================================================================
// Module   : a2_writeback
// Purpose  : Write-back stage. Selects the write-back value, holds the EX/WB
//            pipeline register, owns the register file and provides the
//            decode read ports with write-through bypass. Its registered
//            outputs feed the EX-stage forwarding unit.
// Ports    : clk, reset                    - clock / synchronous reset
//            SEtoReg_in, WriteReg_in, rd_in, sum, extended - from EX
//            hold, flush                   - stall / bubble controls
//            rs1_addr, rs2_addr -> read_data1, read_data2 (bypassed reads)
//            EX_WB_rd, forwarded_data, WriteReg_wb - EX/WB register fields
// Revision : 1.0 - initial release
// ============================================================================
module a2_writeback #(
    parameter int DATA_W = a2_pkg::DATA_W,
    parameter int ADDR_W = a2_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SEtoReg_in,
    input  logic              WriteReg_in,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic [DATA_W-1:0] sum,
    input  logic [DATA_W-1:0] extended,
    input  logic              hold,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [ADDR_W-1:0] EX_WB_rd,
    output logic [DATA_W-1:0] forwarded_data,
    output logic              WriteReg_wb
);

    import a2_pkg::*;

    logic [DATA_W-1:0] w_wb_data;
    ex_wb_t            r_ex_wb;
    logic [DATA_W-1:0] w_rf_rdata1;
    logic [DATA_W-1:0] w_rf_rdata2;
    logic              w_hit1;
    logic              w_hit2;

    assign w_wb_data = SEtoReg_in ? extended : sum;

    // Flush still captures rd/data so the bubble carries the instruction's
    // fields; only the write enable is killed. Flush overrides hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_wb <= '0;
        end else if (flush) begin
            r_ex_wb.write_reg <= 1'b0;
            r_ex_wb.rd        <= rd_in;
            r_ex_wb.data      <= w_wb_data;
        end else if (!hold) begin
            r_ex_wb.write_reg <= WriteReg_in;
            r_ex_wb.rd        <= rd_in;
            r_ex_wb.data      <= w_wb_data;
        end
    end

    assign EX_WB_rd       = r_ex_wb.rd;
    assign forwarded_data = r_ex_wb.data;
    assign WriteReg_wb    = r_ex_wb.write_reg;

    // A held writing instruction rewrites the same value every cycle,
    // which is harmless.
    a2_register_file #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_register_file (
        .clk      (clk),
        .rst      (reset),
        .i_we     (r_ex_wb.write_reg),
        .i_waddr  (r_ex_wb.rd),
        .i_wdata  (r_ex_wb.data),
        .i_raddr1 (rs1_addr),
        .i_raddr2 (rs2_addr),
        .o_rdata1 (w_rf_rdata1),
        .o_rdata2 (w_rf_rdata2)
    );

    // Write-through bypass: the instruction in WB is visible to readers in
    // the same cycle, one cycle before the array is updated.
    assign w_hit1 = r_ex_wb.write_reg && (rs1_addr == r_ex_wb.rd);
    assign w_hit2 = r_ex_wb.write_reg && (rs2_addr == r_ex_wb.rd);

    assign read_data1 = w_hit1 ? r_ex_wb.data : w_rf_rdata1;
    assign read_data2 = w_hit2 ? r_ex_wb.data : w_rf_rdata2;

endmodule : a2_writeback
`default_nettype wire

// File: doc/a2_writeback.md
# a2_writeback

Write-back (WB) stage of the 8-bit pipelined datapath: holds the EX/WB pipeline register, selects the write-back value (adder sum or sign-extended immediate), and owns the 8-entry register file. It is the producer end of the EX-stage forwarding path: it drives the `EX_WB_rd` and `forwarded_data` signals that the EX stage consumes. It also serves the register read ports used by decode.

## Interface
- `DATA_W`, 8: datapath / register width.
- `ADDR_W`, 3: register address width (2^ADDR_W registers).

Clock and reset are decided: one clock; reset is synchronous and active-high.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `SEtoReg_in`  in  1  from EX. 1 = write `extended`; 0 = write `sum`.
- `WriteReg_in`  in  1  from EX. The instruction writes the register file.
- `rd_in`  in  ADDR_W  from EX. Destination register.
- `sum`  in  DATA_W  from EX. Adder result.
- `extended`  in  DATA_W  from EX. Sign-extended immediate.
- `hold`  in  1  stall. The EX/WB register keeps its contents.
- `flush`  in  1  bubble. The captured instruction becomes a non-writing NOP.
- `rs1_addr`, `rs2_addr`  in  ADDR_W each  read addresses.
- `read_data1`, `read_data2`  out  DATA_W each  read data, with write-through bypass.
- `EX_WB_rd`  out  ADDR_W  registered destination; goes to the EX forwarding unit.
- `forwarded_data`  out  DATA_W  registered write-back value; goes to the EX operand muxes.
- `WriteReg_wb`  out  1  registered write enable; qualifies `EX_WB_rd`.

## Operation
- **Write-back select.** `wb_data = SEtoReg_in ? extended : sum`. This is combinational, ahead of the EX/WB register.
- **EX/WB register.** Fields: `{WriteReg, rd, data}`. Update priority at each rising edge:
  - `reset`: all fields load 0.
  - else `flush`: `WriteReg` loads 0; `rd` and `data` load the inputs normally.
  - else `hold`: all fields are kept.
  - else: `{WriteReg_in, rd_in, wb_data}` is captured.
  - `flush` overrides `hold`.
- **Outputs.** `EX_WB_rd`, `forwarded_data` and `WriteReg_wb` are the register fields, driven directly with no logic after the flops.
- **Register file.**
  - 2^ADDR_W × DATA_W entries.
  - Every entry, including r0, is writable; there is no hardwired zero.
  - Write port: writes `data` into `rd` at the rising edge when `WriteReg_wb=1` and `reset=0`.
  - A held, writing instruction rewrites the same value each cycle, which is idempotent.
- **Read ports.**
  - Combinational, asynchronous.
  - Bypass: if `WriteReg_wb=1` and `rsN_addr == EX_WB_rd`, `read_data` = `forwarded_data`. Otherwise it is the array content.
  - Both ports may hit the same address or the bypass at the same time.
- **Forwarding contract.** `EX_WB_rd` is meaningful only while `WriteReg_wb=1`. The EX forwarding comparison must be qualified with `WriteReg_wb`.
- **Reset values.** All outputs are 0 and every register-file entry is 0. As a result, `read_data1` and `read_data2` read 0 for any address.

## Timing
- **Cycle N.** EX outputs are valid.
- **Edge ending N.** The EX/WB register captures them.
- **Cycle N+1.**
  - `EX_WB_rd`, `forwarded_data` and `WriteReg_wb` reflect instruction N.
  - A read of rd returns the new value through the bypass.
- **Edge ending N+1.** The array is written.
- **Cycle N+2 onward.** A read returns the new value from the array.
- **Back-to-back writes to the same rd.** The younger value wins from the cycle it is in WB onward.
- **Reset at the edge where a write is pending.** Reset wins: the write is dropped and the entry reads 0.
- **Reset asserted mid-hold.** The held instruction is discarded.
- **Latency.** EX to forwarded value is 1 cycle. EX to architectural state is 2 cycles; with the bypass it is visible after 1.

## Structure
- **Shared package `a2_pkg`:**
  - `DATA_W` and `ADDR_W` constants.
  - A typedef for the EX/WB register bundle `{WriteReg, rd, data}`.
  - The register count, `NUM_REGS = 1 << ADDR_W`.
- **Sub-module `a2_register_file`:** array, one synchronous write port, two asynchronous read ports, synchronous reset.
  - The bypass is kept in `a2_writeback`, not in `a2_register_file`.
- The pipeline register and the write-back mux are inline in `a2_writeback`.

## Test plan
1. **Reset.** Assert `reset` for 1 cycle → `EX_WB_rd=0`, `forwarded_data=0x00`, `WriteReg_wb=0`. Sweeping `rs1_addr`/`rs2_addr` over 0–7 reads 0x00 on both ports.
2. **Sum write.** `WriteReg_in=1`, `SEtoReg_in=0`, `rd_in=3`, `sum=0x30`, `extended=0xFE` →
   - next cycle: `forwarded_data=0x30`, `EX_WB_rd=3`, `WriteReg_wb=1`, and `rs1_addr=3` reads 0x30 (bypass);
   - cycle after, with new inputs `WriteReg_in=0`: `rs2_addr=3` still reads 0x30 (array).
3. **Extended write to r0.** `SEtoReg_in=1`, `rd_in=0`, `extended=0xFE`, `WriteReg_in=1` → `forwarded_data=0xFE`; r0 later reads 0xFE.
4. **No write.** `WriteReg_in=0`, `rd_in=5`, `sum=0x55` → `WriteReg_wb=0`; `rs1_addr=5` reads 0x00 (no bypass), and r5 stays 0x00.
5. **Hold, then flush.**
   - Capture `rd=2`, data 0x20. Then `hold=1` for 3 cycles with inputs `rd=4`, `sum=0x44` → outputs stay `2`/0x20; r4 stays 0x00.
   - Then `hold=1`, `flush=1` → `WriteReg_wb=0`.
6. **Back-to-back writes, then reset.**
   - Writes to r6 of 0x11 then 0x22 on consecutive cycles → reads return 0x11 for one cycle, then 0x22.
   - Next, a write of 0x77 to r7 is captured. Assert `reset` at the edge where the r7 write is pending → r7 reads 0x00 and r6 reads 0x00.
